// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate byte cache
// sitting between a pipeline's EX/MEM stage and a slow backing store.
// Each of LINES lines holds one byte; LINES must be a power of two in 2..128.
// Optional build macro DCACHE_STATS_EN adds saturating read hit/miss counters.
module data_cache #(
  parameter int LINES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic       flush,
  output logic [7:0] cpu_rdata,
  output logic       rdata_valid,
  output logic       stall,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_read,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 8 - IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [7:0]       data_mem [LINES];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             wr_req, rd_req, line_hit, idle, fill_now, flush_now;

  // The request is decoded from the CPU address; an outstanding miss is
  // completed from the latched mem_addr, so CPU-side changes outside IDLE
  // cannot corrupt the fill.
  assign req_idx  = cpu_addr[IDX_W-1:0];
  assign req_tag  = cpu_addr[7:IDX_W];
  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[7:IDX_W];

  // A simultaneous read and write is treated purely as a write.
  assign wr_req    = cpu_write;
  assign rd_req    = cpu_read & ~cpu_write;
  assign line_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign idle      = (state == IDLE);
  assign fill_now  = (state == RD_MISS) && mem_ready;
  assign flush_now = idle && flush && !cpu_read && !cpu_write;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the combinational stall seen by the pipeline.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nxt = WR_THRU;
          stall     = 1'b1;
        end else if (rd_req && !line_hit) begin
          state_nxt = RD_MISS;
          stall     = 1'b1;
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem_ready) state_nxt = IDLE;
      end
      WR_THRU: begin
        stall = 1'b1;
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag/data array writes: store hits update data, miss fills load both.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset; valid_q alone decides
    // whether their contents mean anything, which keeps them RAM-mappable.
    if (!rst) begin
      if (idle && wr_req && line_hit) begin
        data_mem[req_idx] <= cpu_wdata;
      end else if (fill_now) begin
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= mem_rdata;
      end
    end
  end

  // Valid bits, load result and registered backing-store request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      cpu_rdata   <= 8'h00;
      rdata_valid <= 1'b0;
      mem_addr    <= 8'h00;
      mem_wdata   <= 8'h00;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            mem_write <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end else if (rd_req) begin
            if (line_hit) begin
              cpu_rdata   <= data_mem[req_idx];
              rdata_valid <= 1'b1;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= cpu_addr;
            end
          end else if (flush_now) begin
            valid_q <= '0;
          end
        end
        RD_MISS: begin
          if (mem_ready) begin
            valid_q[fill_idx] <= 1'b1;
            cpu_rdata         <= mem_rdata;
            rdata_valid       <= 1'b1;
            mem_read          <= 1'b0;
          end
        end
        WR_THRU: begin
          if (mem_ready) mem_write <= 1'b0;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating counters of accepted reads, split by hit and miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (idle && rd_req) begin
      if (line_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
